// File: rtl/traffic_light_fsm.sv
// Highway/farm-road traffic light controller: state, phase timer and Moore lamp decode.
// Define TLC_ALL_RED_EN to insert an all-red clearance phase after each yellow.
module traffic_light_fsm #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned HG_MIN  = 16,
    parameter int unsigned Y_TIME  = 4,
    parameter int unsigned FG_MIN  = 4,
    parameter int unsigned FG_MAX  = 12,
    parameter int unsigned AR_TIME = 2
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic       Tick_i,
    input  logic       Car_i,
    output logic       HR,
    output logic       HY,
    output logic       HG,
    output logic       FR,
    output logic       FY,
    output logic       FG,
    output logic [2:0] State_o,
    output logic       Cycle_o
);

    typedef enum logic [2:0] {
        HWY_GREEN   = 3'd0,
        HWY_YELLOW  = 3'd1,
        FARM_GREEN  = 3'd2,
        FARM_YELLOW = 3'd3,
        ALL_RED_A   = 3'd4,
        ALL_RED_B   = 3'd5
    } state_t;

    // Exit thresholds expressed as the pre-increment timer value of the last tick.
    localparam logic [CNT_W-1:0] HG_LAST  = CNT_W'(HG_MIN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(Y_TIME - 1);
    localparam logic [CNT_W-1:0] FGN_LAST = CNT_W'(FG_MIN - 1);
    localparam logic [CNT_W-1:0] FGX_LAST = CNT_W'(FG_MAX - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(AR_TIME - 1);

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] timer;
    logic             advance;
    logic             invalid;

    always_comb begin
        nextState = state;
        advance   = 1'b0;
        invalid   = 1'b0;
        case (state)
            HWY_GREEN: begin
                if (timer >= HG_LAST && Car_i) begin
                    advance   = 1'b1;
                    nextState = HWY_YELLOW;
                end
            end
            HWY_YELLOW: begin
                if (timer == Y_LAST) begin
                    advance = 1'b1;
`ifdef TLC_ALL_RED_EN
                    nextState = ALL_RED_A;
`else
                    nextState = FARM_GREEN;
`endif
                end
            end
            FARM_GREEN: begin
                if ((timer >= FGN_LAST && !Car_i) || timer == FGX_LAST) begin
                    advance   = 1'b1;
                    nextState = FARM_YELLOW;
                end
            end
            FARM_YELLOW: begin
                if (timer == Y_LAST) begin
                    advance = 1'b1;
`ifdef TLC_ALL_RED_EN
                    nextState = ALL_RED_B;
`else
                    nextState = HWY_GREEN;
`endif
                end
            end
            // Without the clearance build nothing enters these; they still drain to green.
            ALL_RED_A: begin
                if (timer == AR_LAST) begin
                    advance   = 1'b1;
                    nextState = FARM_GREEN;
                end
            end
            ALL_RED_B: begin
                if (timer == AR_LAST) begin
                    advance   = 1'b1;
                    nextState = HWY_GREEN;
                end
            end
            default: begin
                invalid   = 1'b1;
                nextState = HWY_GREEN;
            end
        endcase
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state   <= HWY_GREEN;
            timer   <= '0;
            Cycle_o <= 1'b0;
        end else begin
            Cycle_o <= 1'b0;
            if (invalid) begin
                state <= HWY_GREEN;
                timer <= '0;
            end else if (Tick_i) begin
                if (advance) begin
                    state   <= nextState;
                    timer   <= '0;
                    Cycle_o <= (nextState == HWY_GREEN);
                end else if (timer != '1) begin
                    timer <= timer + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        {HR, HY, HG, FR, FY, FG} = '0;
        case (state)
            HWY_GREEN:            {HR, HY, HG, FR, FY, FG} = 6'b001100;
            HWY_YELLOW:           {HR, HY, HG, FR, FY, FG} = 6'b010100;
            FARM_GREEN:           {HR, HY, HG, FR, FY, FG} = 6'b100001;
            FARM_YELLOW:          {HR, HY, HG, FR, FY, FG} = 6'b100010;
            ALL_RED_A, ALL_RED_B: {HR, HY, HG, FR, FY, FG} = 6'b100100;
            default:              {HR, HY, HG, FR, FY, FG} = '0;
        endcase
    end

    assign State_o = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: directed dwell checks plus random ticks/sensor.
// The reference model counts ticks spent in each phase and applies the road rules directly.
module tb_traffic_light_fsm;

    localparam int CNT_W   = 8;
    localparam int HG_MIN  = 16;
    localparam int Y_TIME  = 4;
    localparam int FG_MIN  = 4;
    localparam int FG_MAX  = 12;
    localparam int AR_TIME = 2;
    localparam int SAT     = (1 << CNT_W) - 1;
`ifdef TLC_ALL_RED_EN
    localparam bit ALLRED = 1'b1;
`else
    localparam bit ALLRED = 1'b0;
`endif

    logic       Clk_i = 1'b0;
    logic       Reset_i;
    logic       Tick_i;
    logic       Car_i;
    logic       HR, HY, HG, FR, FY, FG;
    logic [2:0] State_o;
    logic       Cycle_o;

    int   nChecks = 0;
    int   nErr    = 0;
    int   mPhase;
    int   mCnt;
    logic mCycle;
    int   cyc;
    int   tickDiv;
    logic carLevel;
    logic carOnIdle;
    logic randTick;

    traffic_light_fsm #(
        .CNT_W  (CNT_W),
        .HG_MIN (HG_MIN),
        .Y_TIME (Y_TIME),
        .FG_MIN (FG_MIN),
        .FG_MAX (FG_MAX),
        .AR_TIME(AR_TIME)
    ) dut (
        .Clk_i  (Clk_i),
        .Reset_i(Reset_i),
        .Tick_i (Tick_i),
        .Car_i  (Car_i),
        .HR     (HR),
        .HY     (HY),
        .HG     (HG),
        .FR     (FR),
        .FY     (FY),
        .FG     (FG),
        .State_o(State_o),
        .Cycle_o(Cycle_o)
    );

    always #5 Clk_i = ~Clk_i;

    function automatic logic [5:0] expLamps(input int p);
        case (p)
            0:       return 6'b001100;
            1:       return 6'b010100;
            2:       return 6'b100001;
            3:       return 6'b100010;
            4, 5:    return 6'b100100;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic modelReset();
        mPhase = 0;
        mCnt   = 0;
        mCycle = 1'b0;
    endtask

    // One clock edge of the reference: a phase ends on the tick that completes its dwell.
    task automatic modelTick(input logic tick, input logic car);
        int   done;
        int   nxt;
        logic leave;
        mCycle = 1'b0;
        if (!tick) return;
        done  = mCnt + 1;
        leave = 1'b0;
        nxt   = mPhase;
        case (mPhase)
            0: if (car && done >= HG_MIN) begin leave = 1'b1; nxt = 1; end
            1: if (done == Y_TIME) begin leave = 1'b1; nxt = ALLRED ? 4 : 2; end
            2: if ((done >= FG_MIN && !car) || done == FG_MAX) begin leave = 1'b1; nxt = 3; end
            3: if (done == Y_TIME) begin leave = 1'b1; nxt = ALLRED ? 5 : 0; end
            4: if (done == AR_TIME) begin leave = 1'b1; nxt = 2; end
            5: if (done == AR_TIME) begin leave = 1'b1; nxt = 0; end
            default: begin leave = 1'b1; nxt = 0; end
        endcase
        if (leave) begin
            mCycle = (nxt == 0);
            mPhase = nxt;
            mCnt   = 0;
        end else begin
            mCnt = (done > SAT) ? SAT : done;
        end
    endtask

    task automatic check(input string tag);
        nChecks++;
        assert (State_o === 3'(mPhase)) else begin
            nErr++;
            $error("FAIL %s.state got %0d want %0d", tag, State_o, mPhase);
        end
        nChecks++;
        assert ({HR, HY, HG, FR, FY, FG} === expLamps(mPhase)) else begin
            nErr++;
            $error("FAIL %s.lamps got %b want %b", tag, {HR, HY, HG, FR, FY, FG}, expLamps(mPhase));
        end
        nChecks++;
        assert (Cycle_o === mCycle) else begin
            nErr++;
            $error("FAIL %s.cycle got %b want %b", tag, Cycle_o, mCycle);
        end
    endtask

    task automatic step(input string tag);
        logic t;
        logic c;
        t = randTick ? (($urandom % 4) != 0) : ((cyc % tickDiv) == 0);
        c = carOnIdle ? !t : carLevel;
        Tick_i = t;
        Car_i  = c;
        @(posedge Clk_i);
        #1;
        cyc++;
        modelTick(t, c);
        check(tag);
    endtask

    // Steps until State_o leaves 'code'; want < 0 skips the length check.
    task automatic dwell(input int code, input int want, input int dropAt, input string tag);
        int n;
        n = 0;
        while (State_o === 3'(code) && n < 1000) begin
            if (n == dropAt) carLevel = 1'b0;
            step(tag);
            n++;
        end
        if (want >= 0) begin
            nChecks++;
            assert (n == want) else begin
                nErr++;
                $error("FAIL %s.dwell got %0d want %0d", tag, n, want);
            end
        end
    endtask

    task automatic expectBit(input logic got, input logic want, input string tag);
        nChecks++;
        assert (got === want) else begin
            nErr++;
            $error("FAIL %s got %b want %b", tag, got, want);
        end
    endtask

    initial begin
        Reset_i   = 1'b1;
        Tick_i    = 1'b0;
        Car_i     = 1'b0;
        cyc       = 0;
        tickDiv   = 1;
        carLevel  = 1'b1;
        carOnIdle = 1'b0;
        randTick  = 1'b0;
        modelReset();
        repeat (2) @(posedge Clk_i);
        #1;
        check("reset");
        Reset_i = 1'b0;

        // Car present from release, dropped one cycle into farm green.
        dwell(0, HG_MIN, -1, "hg");
        dwell(1, Y_TIME, -1, "hy");
        if (ALLRED) dwell(4, AR_TIME, -1, "arA");
        dwell(2, FG_MIN, 1, "fgDrop");
        dwell(3, Y_TIME, -1, "fy");
        if (ALLRED) dwell(5, AR_TIME, -1, "arB");
        expectBit(Cycle_o, 1'b1, "cyclePulse");
        step("postCycle");
        expectBit(Cycle_o, 1'b0, "cycleEnd");

        // Car held: farm green runs to its maximum.
        carLevel = 1'b1;
        dwell(0, -1, -1, "hg2");
        dwell(1, Y_TIME, -1, "hy2");
        if (ALLRED) dwell(4, AR_TIME, -1, "arA2");
        dwell(2, FG_MAX, -1, "fgMax");
        dwell(3, Y_TIME, -1, "fy2");
        if (ALLRED) dwell(5, AR_TIME, -1, "arB2");

        // Asynchronous reset in the middle of farm green.
        dwell(0, HG_MIN, -1, "hg3");
        dwell(1, Y_TIME, -1, "hy3");
        if (ALLRED) dwell(4, AR_TIME, -1, "arA3");
        repeat (5) step("fgRun");
        Reset_i = 1'b1;
        #2;
        modelReset();
        check("asyncReset");
        @(posedge Clk_i);
        #1;
        check("resetHeld");
        Reset_i = 1'b0;

        // No car for a long time: highway green holds, timer saturates, then car releases it.
        carLevel = 1'b0;
        repeat (300) step("satIdle");
        expectBit(State_o === 3'd0, 1'b1, "satStillGreen");
        carLevel = 1'b1;
        step("satGo");
        expectBit(State_o === 3'd1, 1'b1, "satToYellow");

        // One tick every third clock: dwells stretch threefold.
        tickDiv = 3;
        cyc     = 1;
        dwell(1, 3 * Y_TIME, -1, "hyDiv");
        if (ALLRED) dwell(4, 3 * AR_TIME, -1, "arADiv");
        dwell(2, 3 * FG_MAX, -1, "fgDiv");
        dwell(3, 3 * Y_TIME, -1, "fyDiv");
        if (ALLRED) dwell(5, 3 * AR_TIME, -1, "arBDiv");
        dwell(0, 3 * HG_MIN, -1, "hgDiv");
        dwell(1, 3 * Y_TIME, -1, "hyDiv2");
        if (ALLRED) dwell(4, -1, -1, "arADiv2");
        dwell(2, -1, -1, "fgDiv2");
        dwell(3, -1, -1, "fyDiv2");
        if (ALLRED) dwell(5, -1, -1, "arBDiv2");

        // Car pulses only on non-tick clocks are never seen.
        carOnIdle = 1'b1;
        repeat (90) step("idlePulse");
        expectBit(State_o === 3'd0, 1'b1, "idlePulseIgnored");
        carOnIdle = 1'b0;

        // Random ticks and sensor runs against the model.
        randTick = 1'b1;
        for (int unsigned i = 0; i < 800; i++) begin
            if (($urandom % 8) == 0) carLevel = ~carLevel;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
